pma_rx_align_ctrl: RTL

PMA_RX_ALIGN_CTRL -- requirements
Module: pma_rx_align_ctrl

---
 rtl/pma_rx_align_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/pma_rx_align_ctrl.sv
// Serial comma aligner: hunts K28.5, locks after repeated aligned
// commas and emits 10-bit words on the locked boundary.
module pma_rx_align_ctrl #(
    parameter logic [9:0]  COMMA_N  = 10'h0FA,
    parameter logic [9:0]  COMMA_P  = 10'h305,
    parameter int unsigned LOCK_CNT = 3,
    parameter int unsigned LOSS_CNT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       s_in,
    output logic [9:0] rx_word,
    output logic       word_valid,
    output logic       comma_det,
    output logic       sync,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        LOS  = 2'd0,
        ACQ  = 2'd1,
        SYNC = 2'd2
    } st_e;

    localparam logic [3:0] LOCK4 = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS4 = 4'(LOSS_CNT);

    st_e        st_q, st_d;
    logic [9:0] win_q;
    logic [9:0] nxt;
    logic [3:0] ph_q, ph_d;
    logic [2:0] acq_q, acq_d;
    logic [2:0] err_q, err_d;
    logic       is_comma;
    logic       bnd;
    logic [3:0] acq_inc;
    logic [3:0] err_inc;

    assign nxt      = {win_q[8:0], s_in};
    assign is_comma = (nxt == COMMA_N) || (nxt == COMMA_P);
    assign bnd      = (ph_q == 4'd9);
    assign acq_inc  = {1'b0, acq_q} + 4'd1;
    assign err_inc  = {1'b0, err_q} + 4'd1;
    assign state    = st_q;

    // Next-state, phase and lock/loss counter decisions for this edge
    always_comb begin
        st_d  = st_q;
        ph_d  = bnd ? 4'd0 : ph_q + 4'd1;
        acq_d = acq_q;
        err_d = err_q;
        if (!en) begin
            st_d  = LOS;
            ph_d  = 4'd0;
            acq_d = 3'd0;
            err_d = 3'd0;
        end else if (is_comma) begin
            unique case (st_q)
                LOS: begin
                    st_d  = ACQ;
                    ph_d  = 4'd0;
                    acq_d = 3'd1;
                end
                ACQ: begin
                    if (bnd) begin
                        if (acq_inc >= LOCK4) begin
                            st_d  = SYNC;
                            acq_d = LOCK4[2:0];
                            err_d = 3'd0;
                        end else begin
                            acq_d = acq_inc[2:0];
                        end
                    end else begin
                        ph_d  = 4'd0;
                        acq_d = 3'd1;
                    end
                end
                SYNC: begin
                    if (bnd) begin
                        err_d = 3'd0;
                    end else if (err_inc >= LOSS4) begin
                        st_d  = ACQ;
                        ph_d  = 4'd0;
                        acq_d = 3'd1;
                        err_d = 3'd0;
                    end else begin
                        err_d = err_inc[2:0];
                    end
                end
                default: st_d = LOS;
            endcase
        end
    end

    // Control state, counters and the shift window
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q  <= LOS;
            ph_q  <= 4'd0;
            acq_q <= 3'd0;
            err_q <= 3'd0;
            win_q <= 10'd0;
            sync  <= 1'b0;
        end else begin
            st_q  <= st_d;
            ph_q  <= ph_d;
            acq_q <= acq_d;
            err_q <= err_d;
            sync  <= (st_d == SYNC);
            if (en) begin
                win_q <= nxt;
            end
        end
    end

    // Word output and comma strobe; the word is taken only on a locked boundary
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_word    <= 10'd0;
            word_valid <= 1'b0;
            comma_det  <= 1'b0;
        end else begin
            word_valid <= en && (st_q == SYNC) && bnd;
            comma_det  <= en && is_comma;
            if (en && (st_q == SYNC) && bnd) begin
                rx_word <= nxt;
            end
        end
    end

endmodule
